// File: rtl/disp_scan.sv
// rtl/disp_scan.sv - multiplexed six-digit seven-segment display scanner with decode check
//
// Snapshots six clock-display segment patterns at each frame boundary and
// scans them onto a shared segment bus, one digit at a time.
//
// Ports:
//   clk                    single clock, rising edge
//   rst                    synchronous active-high reset
//   en                     scan enable, sampled at frame boundaries only
//   H1disp..S0disp [6:0]   segment patterns, bit order g f e d c b a
//   seg           [6:0]    shared segment bus
//   dig_en        [5:0]    one-hot digit select, bit0=H1 .. bit5=S0
//   digit_idx     [2:0]    digit currently scanned, 0..5
//   dec_val       [3:0]    decoded digit value (F = blank/off, E = illegal)
//   dec_err                driven pattern is not a legal code
//   frame_done             pulse on the last cycle of a frame
//   err_cnt       [7:0]    saturating count of illegal digit slots
module disp_scan #(
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] H1disp,
  input  logic [6:0] H0disp,
  input  logic [6:0] M1disp,
  input  logic [6:0] M0disp,
  input  logic [6:0] S1disp,
  input  logic [6:0] S0disp,
  output logic [6:0] seg,
  output logic [5:0] dig_en,
  output logic [2:0] digit_idx,
  output logic [3:0] dec_val,
  output logic       dec_err,
  output logic       frame_done,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, SHOW, BLNK} state_t;

  localparam logic [7:0] DW_LAST = 8'(DWELL - 1);
  localparam logic [7:0] BL_LAST = (BLANK == 0) ? 8'd0 : 8'(BLANK - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_idx;
  logic [2:0] w_idx_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       w_capture;
  logic [6:0] r_snap [0:5];
  logic [7:0] r_err_cnt;

  logic       w_show_end;
  logic       w_blnk_end;
  logic       w_digit_end;
  logic       w_frame_end;
  logic [6:0] w_pat;
  logic [3:0] w_dec_val;
  logic       w_dec_err;

  assign w_show_end  = (r_state == SHOW) && (r_cnt == DW_LAST);
  assign w_blnk_end  = (r_state == BLNK) && (r_cnt == BL_LAST);
  // With no blanking the digit ends on its last SHOW cycle.
  assign w_digit_end = (BLANK == 0) ? w_show_end : w_blnk_end;
  assign w_frame_end = w_digit_end && (r_idx == 3'd5);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt + 8'd1;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = 8'd0;
        w_idx_nxt = 3'd0;
        if (en) begin
          w_state_nxt = SHOW;
          w_capture   = 1'b1;
        end
      end
      SHOW: begin
        if (w_show_end) begin
          w_cnt_nxt = 8'd0;
          if (BLANK != 0) w_state_nxt = BLNK;
        end
      end
      BLNK: begin
        if (w_blnk_end) w_cnt_nxt = 8'd0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 8'd0;
        w_idx_nxt   = 3'd0;
      end
    endcase
    if (w_digit_end) begin
      if (r_idx == 3'd5) begin
        // en is only honoured here, so a dropped en never truncates a frame.
        w_idx_nxt = 3'd0;
        if (en) begin
          w_state_nxt = SHOW;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end else begin
        w_idx_nxt   = r_idx + 3'd1;
        w_state_nxt = SHOW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= 3'd0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) r_snap[i] <= 7'h00;
    end else if (w_capture) begin
      r_snap[0] <= H1disp;
      r_snap[1] <= H0disp;
      r_snap[2] <= M1disp;
      r_snap[3] <= M0disp;
      r_snap[4] <= S1disp;
      r_snap[5] <= S0disp;
    end
  end

  always_comb begin
    case (r_idx)
      3'd0:    w_pat = r_snap[0];
      3'd1:    w_pat = r_snap[1];
      3'd2:    w_pat = r_snap[2];
      3'd3:    w_pat = r_snap[3];
      3'd4:    w_pat = r_snap[4];
      3'd5:    w_pat = r_snap[5];
      default: w_pat = 7'h00;
    endcase
  end

  // Decode works on the snapshot, so it lines up with seg in the same cycle.
  always_comb begin
    w_dec_val = 4'hF;
    w_dec_err = 1'b0;
    if (r_state == SHOW) begin
      case (w_pat)
        7'h3F: w_dec_val = 4'h0;
        7'h06: w_dec_val = 4'h1;
        7'h5B: w_dec_val = 4'h2;
        7'h4F: w_dec_val = 4'h3;
        7'h66: w_dec_val = 4'h4;
        7'h6D: w_dec_val = 4'h5;
        7'h7D: w_dec_val = 4'h6;
        7'h07: w_dec_val = 4'h7;
        7'h7F: w_dec_val = 4'h8;
        7'h6F: w_dec_val = 4'h9;
        7'h00: w_dec_val = 4'hF;
        default: begin
          w_dec_val = 4'hE;
          w_dec_err = 1'b1;
        end
      endcase
    end
  end

  // Count each illegal slot once, on its first SHOW cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= 8'd0;
    end else if ((r_state == SHOW) && (r_cnt == 8'd0) && w_dec_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign seg        = (r_state == SHOW) ? w_pat : 7'h00;
  assign dig_en     = (r_state == SHOW) ? (6'b000001 << r_idx) : 6'b000000;
  assign digit_idx  = r_idx;
  assign dec_val    = w_dec_val;
  assign dec_err    = w_dec_err;
  assign frame_done = w_frame_end;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_disp_scan.sv
// tb/tb_disp_scan.sv - directed table-driven bench for disp_scan
module tb_disp_scan;

  typedef struct packed {
    logic [5:0][6:0] pat;
    logic [5:0][3:0] val;
    logic [5:0]      err;
  } vec_t;

  logic       clk;
  logic       rst, en, rst2, en2;
  logic [6:0] H1disp, H0disp, M1disp, M0disp, S1disp, S0disp;
  logic [6:0] seg, seg2;
  logic [5:0] dig_en, dig_en2;
  logic [2:0] digit_idx, digit_idx2;
  logic [3:0] dec_val, dec_val2;
  logic       dec_err, dec_err2;
  logic       frame_done, frame_done2;
  logic [7:0] err_cnt, err_cnt2;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_err = 0;
  vec_t vt [0:5];

  disp_scan u_dut (
    .clk(clk), .rst(rst), .en(en),
    .H1disp(H1disp), .H0disp(H0disp), .M1disp(M1disp),
    .M0disp(M0disp), .S1disp(S1disp), .S0disp(S0disp),
    .seg(seg), .dig_en(dig_en), .digit_idx(digit_idx),
    .dec_val(dec_val), .dec_err(dec_err), .frame_done(frame_done),
    .err_cnt(err_cnt)
  );

  disp_scan #(.DWELL(1), .BLANK(0)) u_dut2 (
    .clk(clk), .rst(rst2), .en(en2),
    .H1disp(H1disp), .H0disp(H0disp), .M1disp(M1disp),
    .M0disp(M0disp), .S1disp(S1disp), .S0disp(S0disp),
    .seg(seg2), .dig_en(dig_en2), .digit_idx(digit_idx2),
    .dec_val(dec_val2), .dec_err(dec_err2), .frame_done(frame_done2),
    .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_inputs(input vec_t v);
    H1disp = v.pat[0];
    H0disp = v.pat[1];
    M1disp = v.pat[2];
    M0disp = v.pat[3];
    S1disp = v.pat[4];
    S0disp = v.pat[5];
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " seg"},        32'(seg), 32'h0);
    chk({nm, " dig_en"},     32'(dig_en), 32'h0);
    chk({nm, " digit_idx"},  32'(digit_idx), 32'h0);
    chk({nm, " dec_val"},    32'(dec_val), 32'hF);
    chk({nm, " dec_err"},    32'(dec_err), 32'h0);
    chk({nm, " frame_done"}, 32'(frame_done), 32'h0);
  endtask

  // Starts at cycle 0 of a frame, ends on its last cycle (before the edge).
  // kind 1: S0disp -> 7D at cycle 10; kind 2: en dropped at cycle 5.
  task automatic run_frame(input string nm, input vec_t v, input int kind);
    for (int c = 0; c < 30; c++) begin
      int d;
      bit show;
      string tag;
      d    = c / 5;
      show = (c % 5) < 4;
      tag  = $sformatf("%s c%0d", nm, c);
      if (kind == 1 && c == 10) S0disp = 7'h7D;
      if (kind == 2 && c == 5) en = 1'b0;
      chk({tag, " dig_en"},     32'(dig_en), show ? (32'h1 << d) : 32'h0);
      chk({tag, " seg"},        32'(seg), show ? 32'(v.pat[d]) : 32'h0);
      chk({tag, " dec_val"},    32'(dec_val), show ? 32'(v.val[d]) : 32'hF);
      chk({tag, " dec_err"},    32'(dec_err), show ? 32'(v.err[d]) : 32'h0);
      chk({tag, " digit_idx"},  32'(digit_idx), 32'(d));
      chk({tag, " frame_done"}, 32'(frame_done), (c == 29) ? 32'h1 : 32'h0);
      if (c == 29) begin
        exp_err = exp_err + $countones(v.err);
        if (exp_err > 255) exp_err = 255;
        chk({tag, " err_cnt"}, 32'(err_cnt), 32'(exp_err));
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    // H=12 M=34 S=56
    vt[0].pat = {7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
    vt[0].val = {4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
    vt[0].err = 6'b000000;
    // H=78 M=90 S=blank,1
    vt[1].pat = {7'h06, 7'h00, 7'h3F, 7'h6F, 7'h7F, 7'h07};
    vt[1].val = {4'h1, 4'hF, 4'h0, 4'h9, 4'h8, 4'h7};
    vt[1].err = 6'b000000;
    // illegal codes on H1, M1, S1
    vt[2].pat = {7'h00, 7'h77, 7'h06, 7'h40, 7'h3F, 7'h01};
    vt[2].val = {4'hF, 4'hE, 4'h1, 4'hE, 4'h0, 4'hE};
    vt[2].err = 6'b010101;
    // H=12 M=34 S=55
    vt[3].pat = {7'h6D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
    vt[3].val = {4'h5, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
    vt[3].err = 6'b000000;
    // H=12 M=34 S=56 after rollover
    vt[4] = vt[0];
    // M0 stuck at 7'h01
    vt[5].pat = {7'h7D, 7'h6D, 7'h01, 7'h4F, 7'h5B, 7'h06};
    vt[5].val = {4'h6, 4'h5, 4'hE, 4'h3, 4'h2, 4'h1};
    vt[5].err = 6'b001000;

    rst = 1'b1; en = 1'b0; rst2 = 1'b1; en2 = 1'b0;
    set_inputs(vt[0]);
    tick();
    en = 1'b1;
    tick();
    chk_idle("reset");
    chk("reset err_cnt", 32'(err_cnt), 32'h0);

    rst = 1'b0; en = 1'b0;
    tick();
    chk_idle("idle en0");

    // Table frames back to back
    en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      run_frame($sformatf("vec%0d", i), vt[i], 0);
      if (i < 2) set_inputs(vt[i + 1]);
      else set_inputs(vt[3]);
      tick();
    end

    // Seconds rollover mid-frame: no tearing
    run_frame("roll_a", vt[3], 1);
    tick();
    run_frame("roll_b", vt[4], 0);
    set_inputs(vt[5]);
    tick();

    // Illegal M0 for 300 frames: err_cnt saturates
    for (int k = 0; k < 300; k++) begin
      run_frame($sformatf("sat%0d", k), vt[5], 0);
      if (k == 299) set_inputs(vt[4]);
      tick();
    end
    chk("sat err_cnt", 32'(err_cnt), 32'hFF);

    // en dropped mid-frame
    run_frame("drop", vt[4], 2);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk_idle($sformatf("post_drop%0d", j));
    end
    en = 1'b1;
    tick();
    chk("restart dig_en", 32'(dig_en), 32'h01);
    chk("restart seg", 32'(seg), 32'h06);

    // Reset during digit 2 SHOW
    repeat (11) tick();
    chk("pre_rst dig_en", 32'(dig_en), 32'h04);
    chk("pre_rst seg", 32'(seg), 32'h4F);
    rst = 1'b1;
    tick();
    chk_idle("mid_rst");
    chk("mid_rst err_cnt", 32'(err_cnt), 32'h0);
    exp_err = 0;
    rst = 1'b0; en = 1'b0;
    repeat (2) tick();
    chk_idle("post_rst");
    en = 1'b1;
    tick();
    chk("resume dig_en", 32'(dig_en), 32'h01);
    chk("resume dec_val", 32'(dec_val), 32'h1);
    en = 1'b0;

    // DWELL=1 BLANK=0 instance
    rst2 = 1'b0; en2 = 1'b1;
    tick();
    for (int c = 0; c < 12; c++) begin
      int d;
      d = c % 6;
      chk($sformatf("fast c%0d dig_en", c), 32'(dig_en2), 32'h1 << d);
      chk($sformatf("fast c%0d seg", c), 32'(seg2), 32'(vt[4].pat[d]));
      chk($sformatf("fast c%0d dec_val", c), 32'(dec_val2), 32'(vt[4].val[d]));
      chk($sformatf("fast c%0d frame_done", c), 32'(frame_done2), (d == 5) ? 32'h1 : 32'h0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
